// File: rtl/serie_paralelo_param.sv
// Serial-to-parallel receiver: hunts for COMMA at any bit offset, locks after
// LOCK_COUNT aligned commas, then strobes out one non-comma word every WIDTH bits.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   SEARCH | comparing the shift register against COMMA on every bit
//   ALIGN  | comma found; counting consecutive commas on word boundaries
//   LOCKED | aligned; emitting data words, watching for comma gaps
module serie_paralelo_param #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
    parameter int              LOCK_COUNT = 4,
    parameter int              MAX_GAP    = 16,
    localparam int             CNT_W      = $clog2(LOCK_COUNT + 1)
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data2send,
    output logic             valid_out,
    output logic             active,
    output logic [CNT_W-1:0] BC_counter,
    output logic             lock_lost
);

    localparam int BIT_W = $clog2(WIDTH);
    // MAX_GAP of 0 or 1 still needs a 1-bit counter.
    localparam int GAP_W = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [CNT_W-1:0] bc_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n, lost_n, active_n;
    logic             wb, is_comma, gap_keep;

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            sr         <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            BC_counter <= '0;
            data2send  <= '0;
            valid_out  <= 1'b0;
            lock_lost  <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= nxt;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_n;
            BC_counter <= bc_n;
            data2send  <= data_n;
            valid_out  <= valid_n;
            lock_lost  <= lost_n;
            active     <= active_n;
        end
    end

    always_comb begin
        nxt       = {sr[WIDTH-2:0], data_in};
        wb        = (bit_cnt == BIT_W'(WIDTH - 1));
        is_comma  = (nxt == COMMA);
        gap_keep  = (MAX_GAP == 0) || ((int'(gap_cnt) + 1) < MAX_GAP);

        state_n   = state;
        bit_cnt_n = wb ? '0 : bit_cnt + 1'b1;
        gap_n     = gap_cnt;
        bc_n      = BC_counter;
        data_n    = data2send;
        valid_n   = 1'b0;
        lost_n    = 1'b0;

        case (state)
            SEARCH: begin
                if (is_comma) begin
                    bit_cnt_n = '0;
                    bc_n      = CNT_W'(1);
                    gap_n     = '0;
                    state_n   = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (wb) begin
                    if (is_comma) begin
                        bc_n = BC_counter + 1'b1;
                        if (bc_n == CNT_W'(LOCK_COUNT)) begin
                            state_n = LOCKED;
                            gap_n   = '0;
                        end
                    end else begin
                        bc_n    = '0;
                        state_n = SEARCH;
                    end
                end
            end
            LOCKED: begin
                // No bit-slip here: commas straddling a boundary are plain data.
                if (wb) begin
                    if (is_comma) begin
                        gap_n = '0;
                    end else if (gap_keep) begin
                        data_n  = nxt;
                        valid_n = 1'b1;
                        gap_n   = (gap_cnt == {GAP_W{1'b1}}) ? gap_cnt : gap_cnt + 1'b1;
                    end else begin
                        lost_n  = 1'b1;
                        bc_n    = '0;
                        gap_n   = '0;
                        state_n = SEARCH;
                    end
                end
            end
            default: state_n = SEARCH;
        endcase

        active_n = (state_n == LOCKED);
    end

endmodule
